// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory port: funct3 codes, FSM states,
// default ack timeout and the byte-enable / alignment helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned LSU_TIMEOUT_CYC = 16;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } lsu_state_e;

    // size: funct3[1:0] (00 byte, 01 half, 10 word)
    function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'b00:   be_gen = 4'b0001 << addr_lo;
            2'b01:   be_gen = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: be_gen = 4'b1111;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'b01:   is_misaligned = addr_lo[0];
            2'b10:   is_misaligned = (addr_lo != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic is_illegal(input logic [2:0] funct3, input logic we);
        is_illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (funct3[2] && we);
    endfunction

endpackage

// File: rtl/lsu_mem_port_lane_align.sv
// Combinational lane steering: store-data replication and byte enables on the
// way out, load lane extraction with sign/zero extension on the way back.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be_o = be_gen(funct3_i[1:0], addr_lo_i);
        case (funct3_i[1:0])
            2'b00:   wdata_o = {4{wdata_i[7:0]}};
            2'b01:   wdata_o = {2{wdata_i[15:0]}};
            default: wdata_o = wdata_i;
        endcase
    end

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (funct3_i)
            F3_B:    rdata_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   rdata_o = {24'd0, byte_sel};
            F3_H:    rdata_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   rdata_o = {16'd0, half_sel};
            default: rdata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store port: one access at a time, ack timeout, extended load result.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of aligning down.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = LSU_TIMEOUT_CYC
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [2:0]        iv_funct3,
    input  logic [ADDR_W-1:0] iv_addr,
    input  logic [DATA_W-1:0] iv_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic              o_misalign,
    output logic [DATA_W-1:0] ov_rdata,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] ov_mem_addr,
    output logic [3:0]        ov_mem_be,
    output logic [DATA_W-1:0] ov_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] iv_mem_rdata
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              mis_q, mis_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              illegal;
    logic              trap;
    logic              access;
    logic [3:0]        be;
    logic [DATA_W-1:0] wdata_rep;
    logic [DATA_W-1:0] ld_data;

    assign illegal = is_illegal(iv_funct3, i_we);
`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = is_misaligned(iv_funct3[1:0], iv_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    lsu_lane_align u_align (
        .funct3_i  (f3_q),
        .addr_lo_i (addr_q[1:0]),
        .wdata_i   (wdata_q),
        .rdata_i   (iv_mem_rdata),
        .be_o      (be),
        .wdata_o   (wdata_rep),
        .rdata_o   (ld_data)
    );

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        mis_d   = mis_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (i_req) begin
                    we_d    = i_we;
                    f3_d    = iv_funct3;
                    addr_d  = iv_addr;
                    wdata_d = iv_wdata;
                    err_d   = illegal;
                    mis_d   = !illegal && trap;
                    if (illegal || trap) begin
                        state_d = S_RESP;
                        rdata_d = '0;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                // ack wins over a timeout expiring in the same cycle
                if (i_mem_ack) begin
                    state_d = S_RESP;
                    err_d   = 1'b0;
                    if (!we_q) rdata_d = ld_data;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
            rdata_q <= rdata_d;
        end
    end

    // Memory-side outputs are driven only while ACCESS so reset clears them at once
    assign access       = (state_q == S_ACCESS);
    assign o_busy       = (state_q != S_IDLE);
    assign o_done       = (state_q == S_RESP);
    assign o_err        = o_done && err_q;
    assign o_misalign   = o_done && mis_q;
    assign ov_rdata     = rdata_q;
    assign o_mem_req    = access;
    assign o_mem_we     = access && we_q;
    assign ov_mem_addr  = access ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign ov_mem_be    = access ? be : 4'b0000;
    assign ov_mem_wdata = access ? wdata_rep : '0;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Randomized self-checking bench for lsu_mem_port against a size/offset arithmetic model.
module tb_lsu_mem_port;

    logic        clk;
    logic        rst_n;
    logic        i_req, i_we, i_mem_ack;
    logic [2:0]  iv_funct3;
    logic [31:0] iv_addr, iv_wdata, iv_mem_rdata;
    logic        o_busy, o_done, o_err, o_misalign, o_mem_req, o_mem_we;
    logic [31:0] ov_rdata, ov_mem_addr, ov_mem_wdata;
    logic [3:0]  ov_mem_be;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    logic [31:0] exp_rdata = '0;

    lsu_mem_port #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req        (i_req),
        .i_we         (i_we),
        .iv_funct3    (iv_funct3),
        .iv_addr      (iv_addr),
        .iv_wdata     (iv_wdata),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err),
        .o_misalign   (o_misalign),
        .ov_rdata     (ov_rdata),
        .o_mem_req    (o_mem_req),
        .o_mem_we     (o_mem_we),
        .ov_mem_addr  (ov_mem_addr),
        .ov_mem_be    (ov_mem_be),
        .ov_mem_wdata (ov_mem_wdata),
        .i_mem_ack    (i_mem_ack),
        .iv_mem_rdata (iv_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic bit illegal_op(input logic [2:0] f3, input bit we);
        return (f3 == 3'd3) || (f3 >= 3'd6) || (f3 >= 3'd4 && we);
    endfunction

    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit trapped(input logic [2:0] f3, input logic [31:0] addr);
        bit t;
        t = ((addr % nbytes(f3)) != 0);
`ifdef LSU_MISALIGN_TRAP_EN
        return t;
`else
        return 1'b0 & t;
`endif
    endfunction

    task automatic scramble();
        i_we      = 1'($urandom);
        iv_funct3 = 3'($urandom);
        iv_addr   = $urandom;
        iv_wdata  = $urandom;
    endtask

    // ack_d: ack presented in ACCESS cycle ack_d+1; negative means never ack
    task automatic run_access(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input int ack_d, input bit poke);
        bit ill, trp, got;
        int n, off;
        logic [63:0] m, wexp, lane;
        logic [31:0] be_exp;
        ill = illegal_op(f3, we);
        trp = !ill && trapped(f3, addr);
        i_req = 1'b1; i_we = we; iv_funct3 = f3; iv_addr = addr; iv_wdata = wdata;
        check_eq("idle_busy", {31'd0, o_busy}, 32'd0);
        @(posedge clk); #1;
        i_req = poke;
        scramble();
        if (ill || trp) begin
            exp_rdata = '0;
            check_eq("trap_done", {31'd0, o_done}, 32'd1);
            check_eq("trap_err", {31'd0, o_err}, {31'd0, ill});
            check_eq("trap_mis", {31'd0, o_misalign}, {31'd0, trp});
            check_eq("trap_req", {31'd0, o_mem_req}, 32'd0);
            check_eq("trap_rdata", ov_rdata, exp_rdata);
        end else begin
            n = nbytes(f3);
            off = ((addr % 4) / n) * n;
            m = (64'd1 << (8 * n)) - 64'd1;
            be_exp = ((32'd1 << n) - 32'd1) << off;
            wexp = '0;
            for (int i = 0; i < 4 / n; i++) wexp = wexp | (({32'd0, wdata} & m) << (8 * n * i));
            lane = ({32'd0, rdata} >> (8 * off)) & m;
            if (!f3[2] && n < 4 && lane[8 * n - 1]) lane = lane | ~m;
            got = 1'b0;
            for (int c = 1; c <= 16; c++) begin
                check_eq("acc_busy_done", {30'd0, o_busy, o_done}, 32'd2);
                check_eq("acc_req_we", {30'd0, o_mem_req, o_mem_we}, {30'd0, 1'b1, we});
                check_eq("acc_addr", ov_mem_addr, {addr[31:2], 2'b00});
                check_eq("acc_be", {28'd0, ov_mem_be}, be_exp);
                if (we) check_eq("acc_wdata", ov_mem_wdata, wexp[31:0]);
                check_eq("acc_rdata_hold", ov_rdata, exp_rdata);
                if (c == ack_d + 1) begin
                    i_mem_ack = 1'b1; iv_mem_rdata = rdata; got = 1'b1;
                end else begin
                    i_mem_ack = 1'b0; iv_mem_rdata = $urandom;
                end
                @(posedge clk); #1;
                i_mem_ack = 1'b0;
                iv_mem_rdata = $urandom;
                if (got) break;
            end
            if (!got) exp_rdata = '0;
            else if (!we) exp_rdata = lane[31:0];
            check_eq("resp_done", {31'd0, o_done}, 32'd1);
            check_eq("resp_err", {31'd0, o_err}, {31'd0, !got});
            check_eq("resp_mis", {31'd0, o_misalign}, 32'd0);
            check_eq("resp_req", {31'd0, o_mem_req}, 32'd0);
            check_eq("resp_rdata", ov_rdata, exp_rdata);
        end
        i_req = 1'b0;
        @(posedge clk); #1;
        check_eq("back_idle", {30'd0, o_busy, o_done}, 32'd0);
        check_eq("idle_rdata", ov_rdata, exp_rdata);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq(tag, {22'd0, o_busy, o_done, o_err, o_misalign, o_mem_req, o_mem_we, ov_mem_be}, 32'd0);
        check_eq({tag, "_addr"}, ov_mem_addr, 32'd0);
        check_eq({tag, "_wdata"}, ov_mem_wdata, 32'd0);
        check_eq({tag, "_rdata"}, ov_rdata, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; i_req = 1'b0; i_mem_ack = 1'b0; iv_mem_rdata = '0;
        i_we = 1'b0; iv_funct3 = '0; iv_addr = '0; iv_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_access(1'b1, 3'b010, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
        run_access(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h0, 1, 1'b1);
        run_access(1'b0, 3'b000, 32'h0000_1002, 32'h0, 32'h12F4_5678, 0, 1'b0);
        check_eq("lb_const", ov_rdata, 32'hFFFF_FFF4);
        run_access(1'b0, 3'b100, 32'h0000_1002, 32'h0, 32'h12F4_5678, 2, 1'b0);
        check_eq("lbu_const", ov_rdata, 32'h0000_00F4);
        run_access(1'b0, 3'b101, 32'h0000_1002, 32'h0, 32'h12F4_5678, 0, 1'b0);
        check_eq("lhu_const", ov_rdata, 32'h0000_12F4);
        run_access(1'b0, 3'b001, 32'h0000_1001, 32'h0, 32'h12F4_5678, 0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
        check_eq("lh_mis_const", ov_rdata, 32'h0);
`else
        check_eq("lh_mis_const", ov_rdata, 32'h0000_5678);
`endif
        run_access(1'b0, 3'b000, 32'h0000_2001, 32'h0, 32'h0000_8000, 0, 1'b0);
        run_access(1'b0, 3'b010, 32'h0000_2000, 32'h0, 32'h1111_2222, -1, 1'b1);
        check_eq("timeout_const", ov_rdata, 32'h0);
        run_access(1'b0, 3'b010, 32'h0000_2004, 32'h0, 32'hCAFE_F00D, 15, 1'b0);
        check_eq("ack_at_limit_const", ov_rdata, 32'hCAFE_F00D);
        run_access(1'b1, 3'b011, 32'h0000_2000, 32'h1, 32'h0, 0, 1'b0);
        run_access(1'b1, 3'b100, 32'h0000_2000, 32'h1, 32'h0, 0, 1'b0);
        run_access(1'b0, 3'b110, 32'h0000_2000, 32'h1, 32'h0, 0, 1'b0);

        // reset in the middle of an access
        run_access(1'b0, 3'b000, 32'h0000_3003, 32'h0, 32'h8000_0000, 0, 1'b0);
        i_req = 1'b1; i_we = 1'b1; iv_funct3 = 3'b010; iv_addr = 32'h4000; iv_wdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        i_req = 1'b0;
        @(posedge clk); #1;
        check_eq("pre_rst_req", {31'd0, o_mem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        exp_rdata = '0;
        repeat (2) begin
            @(posedge clk); #1;
            check_all_zero("rst_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_all_zero("post_rst");
        run_access(1'b1, 3'b010, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0, 0, 1'b1);

        for (int t = 0; t < 150; t++) begin
            int r, d;
            r = int'($urandom_range(0, 9));
            if (r < 7) d = int'($urandom_range(0, 3));
            else if (r == 7) d = 15;
            else if (r == 8) d = -1;
            else d = int'($urandom_range(4, 14));
            run_access(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom, d, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
